// File: rtl/rmii_state_tx.sv
// Serialises one player-state record into an Ethernet II frame on the RMII TX pins.
// Two bits per eth_clk cycle: preamble, SFD, header, 46-byte payload, CRC-32 FCS, then IFG.
module rmii_state_tx #(
  parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          IFG_CYCLES = 48
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic        start_in,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_flag,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] frame_count_out,
  output logic        eth_txen,
  output logic [1:0]  eth_txd
);

  localparam logic [111:0] HDR      = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [31:0]  CRC_POLY = 32'hEDB88320;
  localparam logic [7:0]   IFG_LAST = 8'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic [47:0] pay_word;
  logic [31:0] crc;
  logic [1:0]  hdr_nx;
  logic [1:0]  pay_nx;
  logic [1:0]  fcs_nx;

  // Reflected CRC-32 advanced by one dibit, bit 0 of the dibit goes on the wire first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = (c[0] ^ d[0]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    r = (r[0] ^ d[1]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // Dibit i of a field sent MSB byte first, LSB dibit first; 'last' is the field's byte count minus one.
  function automatic logic [1:0] msb_dibit(input logic [111:0] v, input logic [3:0] last,
                                           input logic [7:0] i);
    logic [6:0] sh;
    sh = {last - i[5:2], 3'b000} + {4'b0000, i[1:0], 1'b0};
    return 2'(v >> sh);
  endfunction

  // Only the first 6 payload bytes carry data; the remaining 40 are zero padding.
  function automatic logic [1:0] pay_dibit(input logic [47:0] w, input logic [7:0] i);
    return (i < 8'd24) ? msb_dibit({64'b0, w}, 4'd5, i) : 2'b00;
  endfunction

  // FCS dibit j is the complemented CRC, bit 0 first.
  function automatic logic [1:0] fcs_dibit(input logic [31:0] c, input logic [3:0] j);
    return 2'(~c >> {j, 1'b0});
  endfunction

  assign cnt_nx = cnt + 8'd1;
  assign hdr_nx = msb_dibit(HDR, 4'd13, (state == HEADER) ? cnt_nx : 8'd0);
  assign pay_nx = pay_dibit(pay_word, (state == PAYLOAD) ? cnt_nx : 8'd0);
  assign fcs_nx = fcs_dibit(crc, (state == FCS) ? cnt_nx[3:0] : 4'd0);

  // Registers always hold the dibit being driven now; cnt indexes it within the current state.
  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      frame_count_out <= 16'd0;
      eth_txen        <= 1'b0;
      eth_txd         <= 2'b00;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            pay_word <= {4'b0, player_x, 1'b0, player_y, 1'b0, direction, 3'b0,
                         game_stat, 1'b0, reset_flag, 3'b0};
            crc      <= '1;
            state    <= PREAMBLE;
            cnt      <= 8'd0;
            busy_out <= 1'b1;
            eth_txen <= 1'b1;
            eth_txd  <= 2'b01;
          end
        end
        PREAMBLE: begin
          eth_txd <= 2'b01;
          if (cnt == 8'd27) begin
            state <= SFD;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        SFD: begin
          if (cnt == 8'd3) begin
            state   <= HEADER;
            cnt     <= 8'd0;
            eth_txd <= hdr_nx;
            crc     <= crc_dibit(crc, hdr_nx);
          end else begin
            cnt     <= cnt_nx;
            eth_txd <= (cnt == 8'd2) ? 2'b11 : 2'b01;
          end
        end
        HEADER: begin
          if (cnt == 8'd55) begin
            state   <= PAYLOAD;
            cnt     <= 8'd0;
            eth_txd <= pay_nx;
            crc     <= crc_dibit(crc, pay_nx);
          end else begin
            cnt     <= cnt_nx;
            eth_txd <= hdr_nx;
            crc     <= crc_dibit(crc, hdr_nx);
          end
        end
        PAYLOAD: begin
          if (cnt == 8'd183) begin
            state   <= FCS;
            cnt     <= 8'd0;
            eth_txd <= fcs_nx;
          end else begin
            cnt     <= cnt_nx;
            eth_txd <= pay_nx;
            crc     <= crc_dibit(crc, pay_nx);
          end
        end
        FCS: begin
          if (cnt == 8'd15) begin
            state           <= IFG;
            cnt             <= 8'd0;
            eth_txen        <= 1'b0;
            eth_txd         <= 2'b00;
            frame_count_out <= frame_count_out + 16'd1;
          end else begin
            cnt      <= cnt_nx;
            eth_txd  <= fcs_nx;
            done_out <= (cnt == 8'd14);
          end
        end
        IFG: begin
          if (cnt == IFG_LAST) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            busy_out <= 1'b0;
          end else begin
            cnt <= cnt_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_state_tx.sv
// Bench for rmii_state_tx: captures the RMII dibit stream and compares it with a byte-level frame model.
module tb_rmii_state_tx;

  logic        eth_clk = 1'b0;
  logic        eth_rst = 1'b1;
  logic        start_in = 1'b0;
  logic [10:0] player_x = '0;
  logic [10:0] player_y = '0;
  logic [8:0]  direction = '0;
  logic [2:0]  game_stat = '0;
  logic        reset_flag = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic [15:0] frame_count_out;
  logic        eth_txen;
  logic [1:0]  eth_txd;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [1:0] cap[$];
  logic [7:0] fb[72];
  logic [1:0] exp_d[288];

  rmii_state_tx dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst), .start_in(start_in),
    .player_x(player_x), .player_y(player_y), .direction(direction),
    .game_stat(game_stat), .reset_flag(reset_flag),
    .busy_out(busy_out), .done_out(done_out), .frame_count_out(frame_count_out),
    .eth_txen(eth_txen), .eth_txd(eth_txd)
  );

  always #10 eth_clk = ~eth_clk;

  always @(negedge eth_clk) begin
    if (eth_txen === 1'b1) cap.push_back(eth_txd);
    if (done_out === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge eth_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic [7:0]  v;
    r = c;
    v = b;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ v[0]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Reference frame as 72 bytes, then expanded to the 288-dibit wire order.
  task automatic build_exp(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                           input logic [2:0] g, input logic rf);
    logic [47:0]  w;
    logic [111:0] h;
    logic [31:0]  c;
    w = {4'b0, x, 1'b0, y, 1'b0, d, 3'b0, g, 1'b0, rf, 3'b0};
    h = {48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_01, 16'h88B5};
    for (int i = 0; i < 7; i++) fb[i] = 8'h55;
    fb[7] = 8'hD5;
    for (int i = 0; i < 14; i++) fb[8 + i] = 8'(h >> (8 * (13 - i)));
    for (int i = 0; i < 46; i++) fb[22 + i] = (i < 6) ? 8'(w >> (8 * (5 - i))) : 8'h00;
    c = 32'hFFFF_FFFF;
    for (int j = 8; j < 68; j++) c = crc_byte(c, fb[j]);
    c = ~c;
    for (int i = 0; i < 4; i++) fb[68 + i] = 8'(c >> (8 * i));
    for (int j = 0; j < 72; j++)
      for (int k = 0; k < 4; k++) exp_d[4 * j + k] = 2'(fb[j] >> (2 * k));
  endtask

  function automatic logic [47:0] cap_word();
    logic [47:0] w;
    logic [7:0]  b;
    w = '0;
    if (cap.size() < 112) return 'x;
    for (int j = 0; j < 6; j++) begin
      b = '0;
      for (int k = 0; k < 4; k++) b = b | (8'(cap[88 + 4 * j + k]) << (2 * k));
      w = {w[39:0], b};
    end
    return w;
  endfunction

  task automatic verify_frame(input string tag);
    int bad = 0;
    int nz = 0;
    logic [31:0] r;
    logic [1:0]  dd;
    check({tag, " txen_cycles"}, 64'(cap.size()), 64'd288);
    for (int i = 0; i < 288 && i < cap.size(); i++)
      if (cap[i] !== exp_d[i]) bad++;
    check({tag, " dibit_errors"}, 64'(bad), 64'd0);
    r = 32'hFFFF_FFFF;
    for (int i = 32; i < 288 && i < cap.size(); i++) begin
      dd = cap[i];
      for (int b = 0; b < 2; b++) begin
        if ((r[0] ^ dd[0]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
        else r = r >> 1;
        dd = dd >> 1;
      end
    end
    check({tag, " crc_residue"}, 64'(r), 64'hDEBB20E3);
    for (int i = 112; i < 272 && i < cap.size(); i++)
      if (cap[i] !== 2'b00) nz++;
    check({tag, " pad_zero"}, 64'(nz), 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    bit seen = 0;
    logic [15:0] fc0;
    while (busy_out === 1'b1 && n < 700) begin
      if (done_out === 1'b1 && !seen) begin
        seen = 1;
        fc0 = frame_count_out;
        tick();
        n++;
        check({tag, " count_step"}, 64'(frame_count_out), 64'(16'(fc0 + 16'd1)));
      end else begin
        tick();
        n++;
      end
    end
    check({tag, " busy_falls"}, 64'(busy_out), 64'd0);
  endtask

  task automatic pulse_start(input logic [10:0] x, input logic [10:0] y, input logic [8:0] d,
                             input logic [2:0] g, input logic rf);
    player_x = x; player_y = y; direction = d; game_stat = g; reset_flag = rf;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send(input string tag, input logic [10:0] x, input logic [10:0] y,
                      input logic [8:0] d, input logic [2:0] g, input logic rf);
    build_exp(x, y, d, g, rf);
    cap.delete();
    pulse_start(x, y, d, g, rf);
    check({tag, " txen_rise"}, 64'(eth_txen), 64'd1);
    check({tag, " busy_rise"}, 64'(busy_out), 64'd1);
    player_x = ~x; player_y = ~y; direction = ~d; game_stat = ~g; reset_flag = ~rf;
    wait_idle(tag);
  endtask

  initial begin
    int d0;
    int n;
    logic [47:0] w;

    // Reset state
    repeat (3) tick();
    check("rst txen", 64'(eth_txen), 64'd0);
    check("rst txd", 64'(eth_txd), 64'd0);
    check("rst busy", 64'(busy_out), 64'd0);
    check("rst done", 64'(done_out), 64'd0);
    check("rst count", 64'(frame_count_out), 64'd0);
    eth_rst = 1'b0;
    tick();

    // Basic frame
    d0 = done_cnt;
    send("basic", 11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
    verify_frame("basic");
    n = 0;
    for (int i = 0; i < 31 && i < cap.size(); i++) if (cap[i] !== 2'b01) n++;
    check("basic preamble", 64'(n), 64'd0);
    check("basic sfd_last", 64'((cap.size() > 31) ? cap[31] : 2'bxx), 64'd3);
    check("basic payload", 64'(cap_word()), 64'h017E_17E8_7020);
    check("basic done_pulses", 64'(done_cnt - d0), 64'd1);
    check("basic txen_low", 64'(eth_txen), 64'd0);

    // Randomized frames
    for (int r = 0; r < 4; r++) begin
      send("rand", 11'($urandom), 11'($urandom), 9'($urandom), 3'($urandom), 1'($urandom));
      verify_frame("rand");
    end

    // Field extremes
    send("ext", 11'd2047, 11'd0, 9'd511, 3'd7, 1'b1);
    verify_frame("ext");
    w = cap_word();
    check("ext x", 64'(w[43:33]), 64'd2047);
    check("ext y", 64'(w[31:21]), 64'd0);
    check("ext dir", 64'(w[19:11]), 64'd511);
    check("ext game", 64'(w[7:5]), 64'd7);
    check("ext reset", 64'(w[3]), 64'd1);
    check("ext pad_bits", 64'({w[47:44], w[32], w[20], w[10:8], w[4], w[2:0]}), 64'd0);

    // Busy: a mid-frame start is dropped, an IFG-47 start is dropped, the next one is taken
    build_exp(11'd100, 11'd200, 9'd300, 3'd2, 1'b0);
    cap.delete();
    d0 = done_cnt;
    pulse_start(11'd100, 11'd200, 9'd300, 3'd2, 1'b0);
    repeat (60) tick();
    pulse_start(11'd5, 11'd6, 9'd7, 3'd3, 1'b1);
    n = 0;
    while (done_out !== 1'b1 && n < 400) begin tick(); n++; end
    check("busy done_seen", 64'(done_out), 64'd1);
    repeat (48) tick();
    check("busy ifg47_busy", 64'(busy_out), 64'd1);
    check("busy ifg47_txen", 64'(eth_txen), 64'd0);
    pulse_start(11'd5, 11'd6, 9'd7, 3'd3, 1'b1);
    check("busy ignored_busy", 64'(busy_out), 64'd0);
    check("busy ignored_txen", 64'(eth_txen), 64'd0);
    verify_frame("busy first");
    check("busy one_frame", 64'(done_cnt - d0), 64'd1);
    send("busy next", 11'd5, 11'd6, 9'd7, 3'd3, 1'b1);
    verify_frame("busy next");

    // Reset during payload
    build_exp(11'd1, 11'd2, 9'd3, 3'd4, 1'b1);
    cap.delete();
    pulse_start(11'd1, 11'd2, 9'd3, 3'd4, 1'b1);
    repeat (140) tick();
    eth_rst = 1'b1;
    tick();
    check("midrst txen", 64'(eth_txen), 64'd0);
    check("midrst busy", 64'(busy_out), 64'd0);
    check("midrst count", 64'(frame_count_out), 64'd0);
    eth_rst = 1'b0;
    tick();
    send("after_rst", 11'd1, 11'd2, 9'd3, 3'd4, 1'b1);
    verify_frame("after_rst");
    check("after_rst count", 64'(frame_count_out), 64'd1);

    // Counter and wrap
    eth_rst = 1'b1;
    tick();
    eth_rst = 1'b0;
    tick();
    d0 = done_cnt;
    for (int r = 0; r < 3; r++)
      send("cnt", 11'($urandom), 11'($urandom), 9'($urandom), 3'($urandom), 1'($urandom));
    check("cnt done_pulses", 64'(done_cnt - d0), 64'd3);
    check("cnt value", 64'(frame_count_out), 64'd3);
    force dut.frame_count_out = 16'hFFFF;
    tick();
    release dut.frame_count_out;
    tick();
    send("wrap", 11'd9, 11'd8, 9'd7, 3'd6, 1'b0);
    verify_frame("wrap");
    check("wrap value", 64'(frame_count_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
